// File: rtl/exec_unit_mc_pkg.sv
// Shared types for the multi-cycle execute unit: op codes, FSM states, op classification.
package exec_pkg;

  localparam int unsigned OpWidth = 5;

  typedef enum logic [OpWidth-1:0] {
    OpAdd   = 5'd0,
    OpSub   = 5'd1,
    OpAnd   = 5'd2,
    OpOr    = 5'd3,
    OpXor   = 5'd4,
    OpSll   = 5'd5,
    OpSrl   = 5'd6,
    OpSra   = 5'd7,
    OpSlt   = 5'd8,
    OpSltu  = 5'd9,
    OpMul   = 5'd16,
    OpMulhu = 5'd17,
    OpDivu  = 5'd18,
    OpRemu  = 5'd19
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } exec_state_e;

  function automatic logic is_multicycle(input logic [OpWidth-1:0] op);
    return (op == OpMul) || (op == OpMulhu) || (op == OpDivu) || (op == OpRemu);
  endfunction

endpackage

// File: rtl/exec_unit_mc_if.sv
// Decode-side and writeback-side handshake bundle of the execute unit.
interface exec_unit_mc_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned OP_W  = 5,
  parameter int unsigned IMM_W = 12,
  parameter int unsigned RD_W  = 5
) ();

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  alu_op;
  logic [XLEN-1:0]  rs1;
  logic [XLEN-1:0]  rs2;
  logic [IMM_W-1:0] imm;
  logic             use_imm;
  logic [RD_W-1:0]  rd;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_data;
  logic [RD_W-1:0]  out_rd;
  logic             busy;

  // Decode / writeback side.
  modport master (
    output in_valid, alu_op, rs1, rs2, imm, use_imm, rd, flush, out_ready,
    input  in_ready, out_valid, out_data, out_rd, busy
  );

  // Execute unit side.
  modport slave (
    input  in_valid, alu_op, rs1, rs2, imm, use_imm, rd, flush, out_ready,
    output in_ready, out_valid, out_data, out_rd, busy
  );

endinterface

// File: rtl/exec_unit_mc_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
module muldiv_iter
  import exec_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               kill,
  input  logic               start,
  input  logic [OpWidth-1:0] op,
  input  logic [XLEN-1:0]    a,
  input  logic [XLEN-1:0]    b,
  output logic [XLEN-1:0]    result,
  output logic               done
);

  localparam int unsigned CntW = $clog2(XLEN);

  logic            running_q;
  logic            is_div_q;
  logic            hi_sel_q;
  logic [CntW-1:0] cnt_q;
  // hi/lo: product halves for multiply, remainder/quotient for divide.
  logic [XLEN-1:0] hi_q, lo_q, opnd_q;
  logic [XLEN-1:0] hi_d, lo_d;

  logic [XLEN:0] mul_sum;
  logic [XLEN:0] div_sh;
  logic [XLEN:0] div_diff;

  // One iteration step; the final result is taken from this next-state value.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_sh   = {hi_q, lo_q[XLEN-1]};
    div_diff = div_sh - {1'b0, opnd_q};
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (is_div_q) begin
      if (!div_diff[XLEN]) begin
        hi_d = div_diff[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_d = div_sh[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_d = mul_sum[XLEN:1];
      lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  assign done   = running_q && (cnt_q == '0);
  assign result = hi_sel_q ? hi_d : lo_d;

  // Operand load on start, then XLEN iterations counting down to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      running_q <= 1'b0;
      is_div_q  <= 1'b0;
      hi_sel_q  <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
    end else if (kill) begin
      running_q <= 1'b0;
      cnt_q     <= '0;
    end else if (start) begin
      running_q <= 1'b1;
      is_div_q  <= (op == OpDivu) || (op == OpRemu);
      hi_sel_q  <= (op == OpMulhu) || (op == OpRemu);
      cnt_q     <= CntW'(XLEN - 1);
      hi_q      <= '0;
      lo_q      <= ((op == OpDivu) || (op == OpRemu)) ? a : b;
      opnd_q    <= ((op == OpDivu) || (op == OpRemu)) ? b : a;
    end else if (running_q) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      if (cnt_q == '0) begin
        running_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/exec_unit_mc.sv
// Execute stage: single-cycle ALU plus iterative mul/div, handshakes and a result slot.
module exec_unit_mc
  import exec_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned OP_W  = 5,
  parameter int unsigned IMM_W = 12,
  parameter int unsigned RD_W  = 5
) (
  input logic           clk,
  input logic           rst,
  exec_unit_mc_if.slave bus
);

  localparam int unsigned ShW = $clog2(XLEN);

  exec_state_e state_q, state_d;

  logic [OpWidth-1:0] op_code;
  logic [XLEN-1:0]    op_a, op_b;
  logic [ShW-1:0]     shamt;
  logic [XLEN-1:0]    alu_res;
  logic               accept, is_mc;
  logic               md_start, md_done;
  logic [XLEN-1:0]    md_result;
  logic [RD_W-1:0]    rd_q;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_data_q, out_data_d;
  logic [RD_W-1:0] out_rd_q, out_rd_d;
  logic            load_alu, load_md;

  assign op_code = OpWidth'(bus.alu_op);
  assign op_a    = bus.rs1;
  assign op_b    = bus.use_imm ? {{(XLEN - IMM_W){bus.imm[IMM_W-1]}}, bus.imm} : bus.rs2;
  assign shamt   = op_b[ShW-1:0];
  assign is_mc   = is_multicycle(op_code);

  assign bus.in_ready  = (state_q == StIdle) && (!out_valid_q || bus.out_ready) && !bus.flush;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.busy      = (state_q == StCalc);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_rd    = out_rd_q;

  // Single-cycle ALU; unknown codes (including the multi-cycle ones) give zero.
  always_comb begin
    alu_res = '0;
    case (op_code)
      OpAdd:   alu_res = op_a + op_b;
      OpSub:   alu_res = op_a - op_b;
      OpAnd:   alu_res = op_a & op_b;
      OpOr:    alu_res = op_a | op_b;
      OpXor:   alu_res = op_a ^ op_b;
      OpSll:   alu_res = op_a << shamt;
      OpSrl:   alu_res = op_a >> shamt;
      OpSra:   alu_res = $unsigned($signed(op_a) >>> shamt);
      OpSlt:   alu_res = XLEN'($signed(op_a) < $signed(op_b));
      OpSltu:  alu_res = XLEN'(op_a < op_b);
      default: alu_res = '0;
    endcase
  end

  muldiv_iter #(
    .XLEN (XLEN)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .kill   (bus.flush),
    .start  (md_start),
    .op     (op_code),
    .a      (op_a),
    .b      (op_b),
    .result (md_result),
    .done   (md_done)
  );

  // FSM next state; flush forces IDLE regardless of where we are.
  always_comb begin
    state_d  = state_q;
    md_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept && is_mc) begin
          state_d  = StCalc;
          md_start = 1'b1;
        end
      end
      StCalc:  if (md_done) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (bus.flush) state_d = StIdle;
  end

  // Result slot: the final iteration loads it so out_valid coincides with DONE.
  always_comb begin
    load_alu    = accept && !is_mc;
    load_md     = (state_q == StCalc) && md_done && !bus.flush;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_rd_d    = out_rd_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (load_alu) begin
      out_valid_d = 1'b1;
      out_data_d  = alu_res;
      out_rd_d    = bus.rd;
    end else if (load_md) begin
      out_valid_d = 1'b1;
      out_data_d  = md_result;
      out_rd_d    = rd_q;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State, destination tag of the in-flight multi-cycle op, and result slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      rd_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_rd_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_rd_q    <= out_rd_d;
      if (md_start) rd_q <= bus.rd;
    end
  end

endmodule

// File: tb/tb_exec_unit_mc.sv
// Directed self-checking bench for exec_unit_mc.
module tb_exec_unit_mc;
  import exec_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  exec_unit_mc_if #(.XLEN(32), .OP_W(5), .IMM_W(12), .RD_W(5)) bus ();

  exec_unit_mc #(
    .XLEN  (32),
    .OP_W  (5),
    .IMM_W (12),
    .RD_W  (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [11:0] imm, input logic use_imm, input logic [4:0] rd);
    bus.alu_op  = op;
    bus.rs1     = a;
    bus.rs2     = b;
    bus.imm     = imm;
    bus.use_imm = use_imm;
    bus.rd      = rd;
  endtask

  // Present one op for exactly one cycle; it must be accepted.
  task automatic issue(input string tag, input alu_op_e op, input logic [31:0] a,
                       input logic [31:0] b, input logic [11:0] imm, input logic use_imm,
                       input logic [4:0] rd);
    drive(op, a, b, imm, use_imm, rd);
    bus.in_valid = 1'b1;
    #1;
    chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic run_alu(input string tag, input alu_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic [11:0] imm, input logic use_imm,
                         input logic [4:0] rd, input logic [31:0] exp);
    issue(tag, op, a, b, imm, use_imm, rd);
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, " out_data"}, bus.out_data, exp);
    chk({tag, " out_rd"}, 32'(bus.out_rd), 32'(rd));
  endtask

  // Multi-cycle op: result must appear XLEN+1 cycles after accept.
  task automatic run_mc(input string tag, input alu_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int lat = 1;
    int busy_cnt = 0;
    int rdy_cnt = 0;
    issue(tag, op, a, b, 12'd0, 1'b0, rd);
    while (!bus.out_valid && lat < 40) begin
      if (bus.busy) busy_cnt++;
      if (bus.in_ready) rdy_cnt++;
      tick();
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'd33);
    chk({tag, " busy cycles"}, 32'(busy_cnt), 32'd32);
    chk({tag, " in_ready while calc"}, 32'(rdy_cnt), 32'd0);
    chk({tag, " in_ready in done"}, 32'(bus.in_ready), 32'd0);
    chk({tag, " out_data"}, bus.out_data, exp);
    chk({tag, " out_rd"}, 32'(bus.out_rd), 32'(rd));
    tick();
    chk({tag, " drained"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    logic [31:0] held;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    drive(OpAdd, 32'd0, 32'd0, 12'd0, 1'b0, 5'd0);

    // Reset state
    tick();
    tick();
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst out_data", bus.out_data, 32'd0);
    chk("rst out_rd", 32'(bus.out_rd), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    rst = 1'b1;
    tick();
    chk("idle in_ready", 32'(bus.in_ready), 32'd1);

    // Single-cycle ALU
    run_alu("add", OpAdd, 32'd5, 32'd7, 12'd0, 1'b0, 5'd3, 32'd12);
    tick();
    chk("add drained", 32'(bus.out_valid), 32'd0);
    run_alu("sub", OpSub, 32'd0, 32'd1, 12'd0, 1'b0, 5'd4, 32'hFFFF_FFFF);
    run_alu("addi", OpAdd, 32'd10, 32'd0, 12'hFFF, 1'b1, 5'd5, 32'd9);
    run_alu("sra", OpSra, 32'h8000_0000, 32'd33, 12'd0, 1'b0, 5'd6, 32'hC000_0000);
    run_alu("slt", OpSlt, 32'hFFFF_FFFF, 32'd1, 12'd0, 1'b0, 5'd7, 32'd1);
    run_alu("sltu", OpSltu, 32'hFFFF_FFFF, 32'd1, 12'd0, 1'b0, 5'd8, 32'd0);
    run_alu("sll", OpSll, 32'h0000_0003, 32'd4, 12'd0, 1'b0, 5'd9, 32'h30);
    run_alu("xor", OpXor, 32'hF0F0_F0F0, 32'hFF00_FF00, 12'd0, 1'b0, 5'd10, 32'h0FF0_0FF0);
    run_alu("undef", alu_op_e'(5'd12), 32'd5, 32'd7, 12'd0, 1'b0, 5'd11, 32'd0);
    tick();

    // Multi-cycle
    run_mc("mul", OpMul, 32'hFFFF_FFFF, 32'd2, 5'd12, 32'hFFFF_FFFE);
    run_mc("mulhu", OpMulhu, 32'hFFFF_FFFF, 32'd2, 5'd13, 32'd1);
    run_mc("divu", OpDivu, 32'd100, 32'd7, 5'd14, 32'd14);
    run_mc("remu", OpRemu, 32'd100, 32'd7, 5'd15, 32'd2);
    run_mc("divu0", OpDivu, 32'd5, 32'd0, 5'd16, 32'hFFFF_FFFF);
    run_mc("remu0", OpRemu, 32'd5, 32'd0, 5'd17, 32'd5);

    // Backpressure: hold result, a pending op must not be accepted
    bus.out_ready = 1'b0;
    run_alu("bp first", OpAdd, 32'd20, 32'd22, 12'd0, 1'b0, 5'd7, 32'd42);
    drive(OpAdd, 32'd1, 32'd2, 12'd0, 1'b0, 5'd8);
    bus.in_valid = 1'b1;
    held = bus.out_data;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.in_ready || !bus.out_valid || bus.out_data !== held || bus.out_rd !== 5'd7) bad++;
      tick();
    end
    chk("bp hold cycles bad", 32'(bad), 32'd0);
    chk("bp held data", bus.out_data, 32'd42);
    bus.out_ready = 1'b1;
    #1;
    chk("bp release in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp b2b out_valid", 32'(bus.out_valid), 32'd1);
    chk("bp b2b out_data", bus.out_data, 32'd3);
    chk("bp b2b out_rd", 32'(bus.out_rd), 32'd8);
    tick();
    chk("bp drained", 32'(bus.out_valid), 32'd0);

    // Flush at iteration 10 of DIVU, with an op presented in the flush cycle
    issue("flush divu", OpDivu, 32'd1000, 32'd3, 12'd0, 1'b0, 5'd9);
    for (int i = 0; i < 9; i++) tick();
    chk("flush busy before", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    drive(OpAdd, 32'd50, 32'd50, 12'd0, 1'b0, 5'd1);
    bus.in_valid = 1'b1;
    #1;
    chk("flush in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush busy", 32'(bus.busy), 32'd0);
    chk("flush out_valid", 32'(bus.out_valid), 32'd0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid || bus.busy) bad++;
      tick();
    end
    chk("flush no stale result", 32'(bad), 32'd0);
    run_alu("post flush add", OpAdd, 32'd1, 32'd1, 12'd0, 1'b0, 5'd2, 32'd2);
    tick();

    // Flush of a held result
    bus.out_ready = 1'b0;
    run_alu("held flush", OpOr, 32'h0F, 32'hF0, 12'd0, 1'b0, 5'd3, 32'hFF);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("held flush out_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;

    // Reset mid-MUL
    issue("rst mul", OpMul, 32'd123, 32'd456, 12'd0, 1'b0, 5'd20);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b0;
    #1;
    chk("rst mul busy", 32'(bus.busy), 32'd0);
    chk("rst mul out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst mul out_data", bus.out_data, 32'd0);
    chk("rst mul out_rd", 32'(bus.out_rd), 32'd0);
    tick();
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid || bus.busy) bad++;
      tick();
    end
    chk("rst mul no result", 32'(bad), 32'd0);
    run_alu("post rst add", OpAdd, 32'd3, 32'd4, 12'd0, 1'b0, 5'd21, 32'd7);
    tick();

    // Reset during a held result
    bus.out_ready = 1'b0;
    run_alu("rst held", OpAdd, 32'd9, 32'd9, 12'd0, 1'b0, 5'd4, 32'd18);
    tick();
    rst = 1'b0;
    #1;
    chk("rst held out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst held out_data", bus.out_data, 32'd0);
    chk("rst held out_rd", 32'(bus.out_rd), 32'd0);
    tick();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    run_mc("post rst mul", OpMul, 32'd6, 32'd7, 5'd22, 32'd42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
